// File: rtl/stream_mux_pkg.sv
// Shared encodings for the round-robin stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_PRIO = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Grant generator for the stream mux: round-robin from the last winner, or fixed lowest-index.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] grant_idx;
    logic          found;
    int            c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        if (mode == MODE_PRIO) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!found && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = IW'(i);
                    found     = 1'b1;
                end
            end
        end else begin
            // Scan last+1 .. last+N so the previous winner is considered last.
            for (int k = 1; k <= int'(N); k++) begin
                c = (int'(last_q) + k) % int'(N);
                if (!found && req[c]) begin
                    grant[c]  = 1'b1;
                    grant_idx = IW'(c);
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        last_d = advance ? grant_idx : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with internal arbitration and a single registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_sel,
    input  logic                 out_ready
);

    localparam int unsigned SW = $clog2(N);

    logic [N-1:0]     grant;
    logic             load;
    logic             advance;
    logic [WIDTH-1:0] data_d;
    logic [SW-1:0]    sel_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SW-1:0]    out_sel_q;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .req     (in_valid),
        .advance (advance),
        .grant   (grant)
    );

    assign load     = ~out_valid_q | out_ready;
    assign in_ready = (load && !rst) ? grant : '0;
    assign advance  = |in_ready;

    // One-hot AND-OR mux and index encoder; grant is never multi-hot.
    always_comb begin
        data_d = '0;
        sel_d  = '0;
        for (int i = 0; i < int'(N); i++) begin
            data_d = data_d | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
            if (grant[i]) begin
                sel_d = sel_d | SW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (load) begin
            out_valid_q <= advance;
            if (advance) begin
                out_data_q <= data_d;
                out_sel_q  <= sel_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: reference arbiter model plus directed scenarios and random traffic.
module tb_stream_mux_rr;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [1:0]       s;
    } word_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [N-1:0]     in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;
    logic [WIDTH-1:0] ch_data [N];

    int    vectors     = 0;
    int    miscompares = 0;
    bit    m_valid;
    int    m_last;
    word_t sb[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign in_data[gi*WIDTH +: WIDTH] = ch_data[gi];
    end

    stream_mux_rr #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference pick: -1 when nothing is valid.
    function automatic int model_pick(input logic [N-1:0] v, input logic md, input int last);
        logic [2*N-1:0] dbl;
        if (md) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
            return -1;
        end
        dbl = {v, v};
        for (int k = 0; k < N; k++) if (dbl[last + 1 + k]) return (last + 1 + k) % N;
        return -1;
    endfunction

    // Check the DUT at the negedge, advance the model to the next posedge, return #1 after it.
    task automatic cycle();
        int           p;
        bit           mload;
        logic [N-1:0] eg;
        word_t        w;
        @(negedge clk);
        p     = model_pick(in_valid, mode, m_last);
        mload = !m_valid || out_ready;
        eg    = '0;
        if (p >= 0 && mload && !rst) eg[p] = 1'b1;
        check("in_ready", in_ready, eg);
        check("out_valid", out_valid, m_valid);
        if (rst) begin
            m_valid = 1'b0;
            m_last  = N - 1;
            sb.delete();
        end else begin
            if (m_valid) begin
                check("sb_depth", sb.size(), 1);
                if (sb.size() > 0) begin
                    check("sb_data", out_data, sb[0].d);
                    check("sb_sel", out_sel, sb[0].s);
                    if (out_ready) w = sb.pop_front();
                end
            end
            if (mload) begin
                if (p >= 0) begin
                    w.d = ch_data[p];
                    w.s = 2'(p);
                    sb.push_back(w);
                    m_last  = p;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = '0;
        for (int i = 0; i < N; i++) ch_data[i] = '0;
        m_valid = 1'b0;
        m_last  = N - 1;
        @(posedge clk);
        #1;

        // Reset then idle.
        repeat (2) begin
            cycle();
            check("rst_data", out_data, 0);
            check("rst_sel", out_sel, 0);
        end
        rst = 1'b0;
        cycle();

        // Round-robin fairness.
        for (int i = 0; i < N; i++) ch_data[i] = 8'hA0 + 8'(i);
        in_valid = '1;
        for (int j = 0; j < 8; j++) begin
            cycle();
            check("rr_data", out_data, 8'hA0 + j % 4);
            check("rr_sel", out_sel, j % 4);
        end

        // Fixed priority.
        mode     = 1'b1;
        in_valid = 4'b1010;
        repeat (4) begin
            cycle();
            check("prio_sel", out_sel, 1);
            check("prio_rdy3", in_ready[3], 0);
        end
        in_valid = 4'b1000;
        cycle();
        check("prio_fall", out_sel, 3);

        // Backpressure holding 8'h5C on channel 2.
        mode       = 1'b0;
        ch_data[2] = 8'h5C;
        in_valid   = 4'b0100;
        cycle();
        check("bp_load", out_data, 8'h5C);
        in_valid  = '1;
        out_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_data", out_data, 8'h5C);
            check("bp_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_next", out_sel, 3);

        // Wrap and skip from last=2 with channels 0 and 2.
        in_valid = 4'b0100;
        cycle();
        check("wrap_pre", out_sel, 2);
        in_valid = 4'b0101;
        cycle();
        check("wrap_0", out_sel, 0);
        cycle();
        check("wrap_2", out_sel, 2);
        cycle();
        check("wrap_0b", out_sel, 0);

        // Reset mid-stream.
        in_valid = 4'b0110;
        cycle();
        check("mid_busy", out_valid, 1);
        rst = 1'b1;
        cycle();
        check("mid_valid", out_valid, 0);
        rst = 1'b0;
        cycle();
        check("mid_first", out_sel, 1);

        // Random traffic against the model.
        for (int t = 0; t < 400; t++) begin
            in_valid  = 4'($urandom);
            mode      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) ch_data[i] = 8'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output. Replaces externally driven select lines with an internal arbiter, round-robin or fixed-priority by mode. One registered output stage gives one-cycle latency at full throughput. Sits between multiple producer streams and a single consumer in the datapath.

## Interface
- `WIDTH`, default 8: data width per channel, ≥1.
- `N`, default 4: number of input channels, ≥2.
- `clk`  input  1: the single clock.
- `rst`  input  1: synchronous, active-high reset.
- `mode`  input  1: arbitration mode; 0 = round-robin, 1 = fixed priority (lowest index wins).
- `in_valid`  input  N: per-channel valid.
- `in_data`  input  N*WIDTH: flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  output  N: per-channel ready; one-hot or zero.
- `out_valid`  output  1: output register holds a word.
- `out_data`  output  WIDTH: registered word.
- `out_sel`  output  $clog2(N): index of the channel that supplied `out_data`.
- `out_ready`  input  1: consumer accepts the word.

## Operation
- `load = ~out_valid | out_ready`. The output register accepts a new word only when `load` is 1.
- Grant `g` (one-hot, N bits) is computed combinationally from `in_valid`, `mode`, and the pointer `last` (index of the most recently granted channel).
  - Round-robin: the first valid channel scanning `last+1, last+2, …` with wrap modulo N.
  - Fixed priority: the lowest-index valid channel; `last` is ignored.
- `in_ready = load ? g : 0`. Input transfer on channel i happens when `in_valid[i] & in_ready[i]`.
- Data path is an AND-OR one-hot mux: `out_data_next = OR over i of (in_data[i] & {WIDTH{g[i]}})`. No priority encoder chain is used on data.
- On a transfer:
  - `out_data`, `out_sel`, and `last` load the granted channel's values.
  - `out_valid` becomes 1.
- When `load` is 1 and no input is valid, `out_valid` becomes 0. `out_data` and `out_sel` hold their previous values.
- When `out_valid & ~out_ready`, the output is stalled. `out_data`, `out_sel`, and `out_valid` are held, and all `in_ready` are 0.
- `last` updates on every transfer in both modes. A mode switch takes effect on the next grant, with no flush.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `last=N-1`. After reset, round-robin therefore favours channel 0 first.

## Timing
- Latency is 1 cycle: a word accepted at edge k is visible on the output after edge k.
- Throughput is one word per cycle when `out_ready` is held at 1.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, and `mode`. There is no combinational path from `in_data` to any output.
- Simultaneous output pop and input push in the same cycle is legal and required for full rate.
- Reset asserted mid-stream:
  - The next edge clears `out_valid`.
  - The word held in the output register is dropped.
  - `in_ready` is 0 while `rst` is high.
- Producers must hold `in_valid` and `in_data` until the transfer; the block does not check this.

## Structure
- Package `stream_mux_pkg` holds the mode encodings: `MODE_RR = 1'b0`, `MODE_PRIO = 1'b1`.
- Sub-module `rr_arbiter` (parameter N) owns `last` and grant generation. Its ports are `clk`, `rst`, `mode`, `req[N]`, `advance`, and `grant[N]`.
- The top level holds the output register, the AND-OR data mux, and a one-hot-to-index encoder that produces `out_sel`.

## Test plan
- Reset then idle:
  - Stimulus: `rst=1` for 2 cycles, all `in_valid=0`.
  - Response: `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0` on every cycle.
- Round-robin fairness:
  - Stimulus: N=4, WIDTH=8, `mode=0`, all channels continuously valid with channel i driving 8'hA0+i, `out_ready=1`.
  - Response: output sequence A0, A1, A2, A3, A0, … with `out_sel` 0, 1, 2, 3, 0, …, one word per cycle.
- Fixed priority:
  - Stimulus: `mode=1`, channels 1 and 3 continuously valid.
  - Response: only channel 1 is ever granted and `in_ready[3]` stays 0. When channel 1 drops, channel 3 is granted the next cycle.
- Backpressure:
  - Stimulus: `out_ready=0` for 3 cycles while `out_valid=1` holding 8'h5C.
  - Response: `out_data` stays 8'h5C, `in_ready=0`, and no word is lost. After `out_ready` returns to 1, the next grant follows round-robin order from the held `out_sel`.
- Round-robin wrap and skip:
  - Stimulus: `last=2`, only channels 0 and 2 valid.
  - Response: channel 0 granted (wrap past 3), then channel 2, then channel 0.
- Reset mid-stream:
  - Stimulus: `rst` pulsed for 1 cycle while `out_valid=1`.
  - Response: `out_valid=0` the next cycle. The first grant afterwards goes to the lowest-index valid channel.
